debounce_sync: RTL and testbench
================================

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 The block SHALL provide parameter STABLE_CYCLES, default 50000: number of consecutive cycles a synchronised input must differ from its output before the output follows it.
REQ-002 The block SHALL provide parameter CNT_W, default 16: stability counter width; legal configurations satisfy 2 <= STABLE_CYCLES <= 2^CNT_W.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port raw_a, input, 1 bit: asynchronous, bouncy source for channel A.
REQ-006 The block SHALL have port raw_b, input, 1 bit: asynchronous, bouncy source for channel B.
REQ-007 The block SHALL have port a, output, 1 bit: clean, registered level for channel A; feeds the flip-flop stage data/J/S/T input.
REQ-008 The block SHALL have port b, output, 1 bit: clean, registered level for channel B; feeds the flip-flop stage K/R input.
REQ-009 The block SHALL have port a_rise, output, 1 bit: one-cycle pulse when a goes 0->1.
REQ-010 The block SHALL have port a_fall, output, 1 bit: one-cycle pulse when a goes 1->0.
REQ-011 The block SHALL have ports b_rise and b_fall, outputs, 1 bit each: as a_rise/a_fall, for channel B.

Function
REQ-012 Each channel SHALL pass its raw input through a 2-flop synchroniser: sync0 <= raw, sync1 <= sync0.
REQ-013 Each channel SHALL keep a CNT_W-bit counter cnt, evaluated every cycle:
- sync1 == output: cnt <= 0.
- Mismatch and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
- Mismatch and cnt == STABLE_CYCLES-1: output <= sync1, cnt <= 0.
REQ-014 A rise/fall pulse SHALL be asserted for exactly the one cycle after the output updates, registered alongside it, with direction matching the new level.
REQ-015 Latency: take the edge that first samples a new stable raw value into sync0 as edge 1; the output SHALL change on edge STABLE_CYCLES+2.
REQ-016 A mismatch run shorter than STABLE_CYCLES cycles in sync1 SHALL leave the output and pulses unchanged and SHALL return cnt to 0 when the run ends; a bounce restarts the count from 0.
REQ-017 Channels A and B SHALL be fully independent; simultaneous transitions on both SHALL update both on the same edge when their timing is equal.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-019 rise and fall of one channel SHALL never be asserted in the same cycle.
REQ-020 All outputs SHALL be driven directly from flops, with no combinational path from raw inputs.

Reset
REQ-021 While rst=1 at a rising edge: sync0, sync1, cnt, a, b and all pulse outputs SHALL be cleared to 0.
REQ-022 Reset asserted mid-count SHALL discard the partial count and any pending update; no pulse SHALL be emitted on the reset edge or on the first edge after release.
REQ-023 After release with raw=1 held, the output SHALL rise on edge STABLE_CYCLES+2 after release, counting the first post-release edge as 1, with a single rise pulse.

Structure
REQ-024 A shared package SHALL hold the STABLE_CYCLES and CNT_W defaults plus a simulation-scale constant STABLE_CYCLES_SIM = 4.
REQ-025 One sub-module, debounce_chan, SHALL implement one channel (ports: clk, rst, raw, level, rise, fall).
REQ-026 debounce_sync SHALL instantiate debounce_chan twice, once for A and once for B.

Verification (STABLE_CYCLES=4)
REQ-027 Clean step: raw_a 0->1 and held -> a=1 on edge 6 after the first sampling edge; a_rise=1 for one cycle; b, b_rise and b_fall stay 0.
REQ-028 Bounce: raw_a pattern 1,0,1,1,0 (one cycle each), then 1 held -> the glitch is ignored; a rises 6 edges after the final 0->1, with exactly one a_rise.
REQ-029 Short pulse: raw_b=1 for 3 cycles, then 0 -> b stays 0, no b_rise or b_fall, cnt back to 0.
REQ-030 Simultaneous: raw_a and raw_b both 0->1 on the same cycle -> a and b rise on the same edge, and a_rise and b_rise pulse together.
REQ-031 Fall: with a=1 stable, raw_a 1->0 held -> a=0 after 6 edges; a_fall pulses one cycle and a_rise stays 0.
REQ-032 Reset mid-count: raw_a=1 held, rst=1 for 1 cycle at count 2 -> all outputs 0, no pulse; a rises 6 edges after release.

Source files
------------

// File: rtl/debounce_sync_pkg.sv
// Shared constants for the two-channel debouncer: production defaults and
// the reduced stability window used in simulation.
package debounce_sync_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 50000;
  localparam int CNT_W_DEFAULT         = 16;
  localparam int STABLE_CYCLES_SIM     = 4;

endpackage : debounce_sync_pkg

// File: rtl/debounce_chan.sv
// One debounced channel: 2-flop synchroniser, stability counter, and
// registered clean level with one-cycle rise/fall pulses.
module debounce_chan
  import debounce_sync_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync0 <= raw;
      r_sync1 <= r_sync0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any agreement with the current level restarts the stability window.
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_level <= r_sync1;
        r_rise  <= r_sync1;
        r_fall  <= ~r_sync1;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

  a_pulse_excl : assert property (@(posedge clk) disable iff (rst) !(r_rise && r_fall));
  a_cnt_bound  : assert property (@(posedge clk) disable iff (rst) r_cnt <= CNT_MAX);

endmodule : debounce_chan

// File: rtl/debounce_sync.sv
// Two independent debounced channels (A, B) feeding a downstream flip-flop
// stage; every output comes straight from a channel register.
module debounce_sync
  import debounce_sync_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT,
  parameter int CNT_W         = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  debounce_chan #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_a),
    .level (a),
    .rise  (a_rise),
    .fall  (a_fall)
  );

  debounce_chan #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_b),
    .level (b),
    .rise  (b_rise),
    .fall  (b_fall)
  );

endmodule : debounce_sync

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with a 4-cycle stability window: table of
// per-edge vectors plus hand sequences for short pulses and mid-count reset.
module tb_debounce_sync;
  import debounce_sync_pkg::*;

  localparam int SC  = STABLE_CYCLES_SIM;
  localparam int CW  = 3;
  localparam int LAT = SC + 2;

  logic clk;
  logic rst;
  logic raw_a;
  logic raw_b;
  logic a, b, a_rise, a_fall, b_rise, b_fall;

  int n_tests;
  int n_fail;

  typedef struct {
    logic       rst;
    logic       raw_a;
    logic       raw_b;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  debounce_sync #(
    .STABLE_CYCLES (SC),
    .CNT_W         (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .a      (a),
    .b      (b),
    .a_rise (a_rise),
    .a_fall (a_fall),
    .b_rise (b_rise),
    .b_fall (b_fall)
  );

  // clock / reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected output vector: {a, b, a_rise, a_fall, b_rise, b_fall}
  function automatic logic [5:0] mk(input logic ea, input logic eb,
                                    input logic ear, input logic eaf,
                                    input logic ebr, input logic ebf);
    return {ea, eb, ear, eaf, ebr, ebf};
  endfunction

  task automatic add(input logic r, input logic ra, input logic rb, input logic [5:0] e);
    vec_t v;
    v.rst   = r;
    v.raw_a = ra;
    v.raw_b = rb;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // drive one edge's inputs, clock once, then compare outputs 1 time unit later
  task automatic apply(input string name, input logic r, input logic ra,
                       input logic rb, input logic [5:0] exp);
    logic [5:0] got;
    rst   = r;
    raw_a = ra;
    raw_b = rb;
    @(posedge clk);
    #1;
    got = {a, b, a_rise, a_fall, b_rise, b_fall};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {a,b,ar,af,br,bf}=%b expected %b", name, got, exp);
    end
    n_tests++;
    if (int'(dut.u_chan_a.r_cnt) > SC - 1 || int'(dut.u_chan_b.r_cnt) > SC - 1) begin
      n_fail++;
      $display("FAIL %s_cnt_bound: got cnt_a=%0d cnt_b=%0d required <= %0d", name,
               dut.u_chan_a.r_cnt, dut.u_chan_b.r_cnt, SC - 1);
    end
  endtask

  initial begin
    int pat[5];
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    raw_a = 1'b0;
    raw_b = 1'b0;
    pat   = '{1, 0, 1, 1, 0};

    // reset state
    for (int i = 0; i < 2; i++) add(1'b1, 1'b0, 1'b0, 6'b0);
    // clean rising step on A; B untouched
    for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, 1'b0, mk(i >= LAT, 1'b0, i == LAT, 1'b0, 1'b0, 1'b0));
    // clean fall on A
    for (int i = 1; i <= 7; i++) add(1'b0, 1'b0, 1'b0, mk(i < LAT, 1'b0, 1'b0, i == LAT, 1'b0, 1'b0));
    // bounce 1,0,1,1,0 is ignored; count restarts at the final 0->1
    for (int i = 0; i < 5; i++) add(1'b0, pat[i] != 0, 1'b0, 6'b0);
    for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, 1'b0, mk(i >= LAT, 1'b0, i == LAT, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 7; i++) add(1'b0, 1'b0, 1'b0, mk(i < LAT, 1'b0, 1'b0, i == LAT, 1'b0, 1'b0));
    // simultaneous rise, then simultaneous fall
    for (int i = 1; i <= 7; i++) add(1'b0, 1'b1, 1'b1, mk(i >= LAT, i >= LAT, i == LAT, 1'b0, i == LAT, 1'b0));
    for (int i = 1; i <= 7; i++) add(1'b0, 1'b0, 1'b0, mk(i < LAT, i < LAT, 1'b0, i == LAT, 1'b0, i == LAT));

    foreach (vecs[i])
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].raw_a, vecs[i].raw_b, vecs[i].exp);

    // short pulse on B: 3 cycles high reaches cnt=SC-1 but never updates b
    for (int i = 1; i <= 3; i++) apply($sformatf("short_hi%0d", i), 1'b0, 1'b0, 1'b1, 6'b0);
    for (int i = 4; i <= 8; i++) begin
      apply($sformatf("short_lo%0d", i), 1'b0, 1'b0, 1'b0, 6'b0);
      if (i == 5) chk_int("short_cnt_peak", int'(dut.u_chan_b.r_cnt), SC - 1);
      if (i == 6) chk_int("short_cnt_clear", int'(dut.u_chan_b.r_cnt), 0);
    end
    chk_int("short_cnt_end", int'(dut.u_chan_b.r_cnt), 0);

    // reset at count 2 discards progress; rise comes LAT edges after release
    for (int i = 1; i <= 4; i++) apply($sformatf("rmc_pre%0d", i), 1'b0, 1'b1, 1'b0, 6'b0);
    chk_int("rmc_cnt_before", int'(dut.u_chan_a.r_cnt), 2);
    apply("rmc_rst", 1'b1, 1'b1, 1'b0, 6'b0);
    chk_int("rmc_cnt_rst", int'(dut.u_chan_a.r_cnt), 0);
    chk_int("rmc_sync0_rst", int'(dut.u_chan_a.r_sync0), 0);
    for (int i = 1; i <= 7; i++)
      apply($sformatf("rmc_post%0d", i), 1'b0, 1'b1, 1'b0,
            mk(i >= LAT, 1'b0, i == LAT, 1'b0, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_debounce_sync
